// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Package     : if_pkg
// Description : Shared constants and helpers for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int INSTR_BYTES = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous power-of-two FIFO with clear; head is read
//               combinationally from the storage array.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_pushData,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic [WIDTH-1:0]       o_headData,
    output logic [clog2(DEPTH):0]  o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int c_PTR_W = clog2(DEPTH);
    localparam int c_CNT_W = clog2(DEPTH) + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_count    = r_count;
    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_headData = r_mem[r_rdPtr];

    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reads are only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_clear && !rst) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    a_noPushWhenFull : assert property (@(posedge clk) disable iff (rst)
        !(i_push && o_full && !i_clear));

endmodule
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_stage
// Description : Instruction fetch with decoupled imem request/response and an
//               in-order prefetch queue; stale responses dropped on branch.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] BranchAddr,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] Instruction,
    output logic              inst_valid,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data
);

    localparam int c_CNT_W = clog2(DEPTH) + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]  c_STEP    = ADDR_W'(INSTR_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    logic [ADDR_W-1:0]  r_fetchPc;
    logic [ADDR_W-1:0]  r_rspPc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop;

    logic [c_CNT_W-1:0] w_qCount;
    logic [c_CNT_W-1:0] w_creditUsed;
    logic               w_qFull;
    logic               w_qEmpty;
    logic               w_reqFire;
    logic               w_dropping;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_pushEntry;
    fetch_entry_t       w_head;

    // Queued plus in-flight entries can never exceed DEPTH, so every
    // accepted response is guaranteed a queue slot.
    assign w_creditUsed   = w_qCount + r_outstanding;
    assign imem_req_valid = !rst && !Branch_taken && (w_creditUsed < c_DEPTH);
    assign imem_req_addr  = r_fetchPc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;

    assign w_dropping  = (r_drop != '0);
    assign w_push      = imem_rsp_valid && !w_dropping && !Branch_taken;
    assign w_pushEntry = '{addr: r_rspPc, instr: imem_rsp_data};

    assign inst_valid  = !w_qEmpty;
    assign w_pop       = inst_valid && !freeze && !Branch_taken;
    assign PC          = (inst_valid ? w_head.addr : '0) + c_STEP;
    assign Instruction = inst_valid ? w_head.instr : '0;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetchQueue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushEntry),
        .i_pop      (w_pop),
        .i_clear    (Branch_taken),
        .o_headData (w_head),
        .o_count    (w_qCount),
        .o_full     (w_qFull),
        .o_empty    (w_qEmpty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc     <= RESET_PC;
            r_rspPc       <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (Branch_taken) begin
            // Everything still in flight belongs to the old path.
            r_fetchPc     <= BranchAddr;
            r_rspPc       <= BranchAddr;
            r_outstanding <= r_outstanding - c_CNT_W'(imem_rsp_valid);
            r_drop        <= r_outstanding - c_CNT_W'(imem_rsp_valid);
        end else begin
            if (w_reqFire) begin
                r_fetchPc <= r_fetchPc + c_STEP;
            end
            if (w_push) begin
                r_rspPc <= r_rspPc + c_STEP;
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_reqFire)
                                           - c_CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid && w_dropping) begin
                r_drop <= r_drop - c_CNT_ONE;
            end
        end
    end

    a_noReqWhenFull : assert property (@(posedge clk) disable iff (rst)
        !(imem_req_valid && w_qFull));

    a_noOrphanResponse : assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (r_outstanding == '0)));

endmodule
`default_nettype wire
